// File: rtl/cnn_tile_pkg.sv
// Shared types for the CNN tiling path.
// Holds the default dimension width (also used by the tiling controller),
// the tile descriptor struct and the pixel-fetch FSM state enum.
package cnn_tile_pkg;

  localparam int unsigned DIM_W = 16;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StStream = 1'b1
  } tile_state_e;

  // Input-window descriptor; origins are signed so windows may start above/left of the image.
  typedef struct packed {
    logic signed [DIM_W:0] in_row;
    logic signed [DIM_W:0] in_col;
    logic [DIM_W-1:0]      in_h;
    logic [DIM_W-1:0]      in_w;
    logic [DIM_W-1:0]      idx;
  } tile_desc_t;

endpackage

// File: rtl/tile_px_addr.sv
// Combinational pixel position check and HWC address generation.
// Ports:
//   i_in_row/i_in_col  signed window origin (DIM_W+1 bits, two's complement)
//   i_row/i_col        offset within the window
//   i_img_h/i_img_w    image dimensions
//   i_channels         channels per pixel (address stride per pixel)
//   i_base             address of pixel (0,0) channel 0
//   o_pad              position lies outside the image
//   o_addr             base + (r*img_w + c)*channels, or 0 when padding
module tile_px_addr #(
  parameter int unsigned DIM_W  = 16,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CH_W   = 16
) (
  input  logic [DIM_W:0]    i_in_row,
  input  logic [DIM_W:0]    i_in_col,
  input  logic [DIM_W-1:0]  i_row,
  input  logic [DIM_W-1:0]  i_col,
  input  logic [DIM_W-1:0]  i_img_h,
  input  logic [DIM_W-1:0]  i_img_w,
  input  logic [CH_W-1:0]   i_channels,
  input  logic [ADDR_W-1:0] i_base,
  output logic              o_pad,
  output logic [ADDR_W-1:0] o_addr
);

  // Signed origin plus unsigned offset cannot overflow DIM_W+2 bits.
  localparam int unsigned PosW = DIM_W + 2;
  localparam int unsigned LinW = 2 * DIM_W + CH_W + 1;
  localparam int unsigned AccW = (LinW > ADDR_W) ? LinW : ADDR_W;

  logic [PosW-1:0] w_r;
  logic [PosW-1:0] w_c;
  logic [AccW-1:0] w_lin;
  logic [AccW-1:0] w_off;
  logic [AccW-1:0] w_sum;

  assign w_r = {i_in_row[DIM_W], i_in_row} + {2'b00, i_row};
  assign w_c = {i_in_col[DIM_W], i_in_col} + {2'b00, i_col};

  // Negative positions are caught by the sign bit; otherwise an unsigned compare suffices.
  assign o_pad = w_r[PosW-1] | w_c[PosW-1] |
                 (w_r >= {2'b00, i_img_h}) | (w_c >= {2'b00, i_img_w});

  // When not padding, r < img_h and c < img_w, so the low DIM_W bits hold the full value.
  assign w_lin  = AccW'(w_r[DIM_W-1:0]) * AccW'(i_img_w) + AccW'(w_c[DIM_W-1:0]);
  assign w_off  = w_lin * AccW'(i_channels);
  assign w_sum  = w_off + AccW'(i_base);
  assign o_addr = o_pad ? '0 : w_sum[ADDR_W-1:0];

  // Address wraps silently at ADDR_W bits.
  if (AccW > ADDR_W) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^w_sum[AccW-1:ADDR_W];
  end

endmodule

// File: rtl/tile_px_fetch.sv
// Tile pixel fetcher: accepts one input-window descriptor at a time and walks it in
// raster order, emitting one pixel request (HWC address of channel 0 or a pad marker)
// per window position toward the line-buffer / DMA read path.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_cfg_*             image geometry / channels / base, sampled on tile accept
//   i_tile_* / o_tile_ready   descriptor valid/ready interface
//   o_px_* / i_px_ready       pixel request valid/ready interface
//   o_tile_done         one-cycle pulse after last pixel accepted or empty tile dropped
//   o_busy              high while streaming a window
// The descriptor register uses cnn_tile_pkg::tile_desc_t, so DIM_W must match the package.
module tile_px_fetch #(
  parameter int unsigned DIM_W  = cnn_tile_pkg::DIM_W,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CH_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DIM_W-1:0]        i_cfg_img_h,
  input  logic [DIM_W-1:0]        i_cfg_img_w,
  input  logic [CH_W-1:0]         i_cfg_channels,
  input  logic [ADDR_W-1:0]       i_cfg_base_addr,
  input  logic                    i_tile_valid,
  output logic                    o_tile_ready,
  input  logic signed [DIM_W:0]   i_tile_in_row,
  input  logic signed [DIM_W:0]   i_tile_in_col,
  input  logic [DIM_W-1:0]        i_tile_in_h,
  input  logic [DIM_W-1:0]        i_tile_in_w,
  input  logic [DIM_W-1:0]        i_tile_idx,
  output logic                    o_px_valid,
  input  logic                    i_px_ready,
  output logic [ADDR_W-1:0]       o_px_addr,
  output logic                    o_px_pad,
  output logic [DIM_W-1:0]        o_px_row,
  output logic [DIM_W-1:0]        o_px_col,
  output logic [DIM_W-1:0]        o_px_tile_idx,
  output logic                    o_px_last,
  output logic                    o_tile_done,
  output logic                    o_busy
);
  import cnn_tile_pkg::*;

  tile_state_e       r_state, w_state_nxt;
  tile_desc_t        r_desc, w_desc_nxt;
  logic [DIM_W-1:0]  r_img_h, w_img_h_nxt;
  logic [DIM_W-1:0]  r_img_w, w_img_w_nxt;
  logic [CH_W-1:0]   r_ch, w_ch_nxt;
  logic [ADDR_W-1:0] r_base, w_base_nxt;
  logic [DIM_W-1:0]  r_row, w_row_nxt;
  logic [DIM_W-1:0]  r_col, w_col_nxt;
  logic              r_done, w_done_nxt;

  logic              w_streaming;
  logic              w_col_end;
  logic              w_last;
  logic              w_pad;
  logic [ADDR_W-1:0] w_addr;

  assign w_streaming = (r_state == StStream);
  assign w_col_end   = (r_col == r_desc.in_w - DIM_W'(1));
  assign w_last      = (r_row == r_desc.in_h - DIM_W'(1)) && w_col_end;

  tile_px_addr #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W),
    .CH_W   (CH_W)
  ) u_addr (
    .i_in_row   (r_desc.in_row),
    .i_in_col   (r_desc.in_col),
    .i_row      (r_row),
    .i_col      (r_col),
    .i_img_h    (r_img_h),
    .i_img_w    (r_img_w),
    .i_channels (r_ch),
    .i_base     (r_base),
    .o_pad      (w_pad),
    .o_addr     (w_addr)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_desc_nxt  = r_desc;
    w_img_h_nxt = r_img_h;
    w_img_w_nxt = r_img_w;
    w_ch_nxt    = r_ch;
    w_base_nxt  = r_base;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_tile_valid) begin
          w_desc_nxt.in_row = i_tile_in_row;
          w_desc_nxt.in_col = i_tile_in_col;
          w_desc_nxt.in_h   = i_tile_in_h;
          w_desc_nxt.in_w   = i_tile_in_w;
          w_desc_nxt.idx    = i_tile_idx;
          w_img_h_nxt       = i_cfg_img_h;
          w_img_w_nxt       = i_cfg_img_w;
          w_ch_nxt          = i_cfg_channels;
          w_base_nxt        = i_cfg_base_addr;
          w_row_nxt         = '0;
          w_col_nxt         = '0;
          // Empty windows are dropped but still reported as done.
          if (i_tile_in_h == '0 || i_tile_in_w == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = StStream;
          end
        end
      end
      StStream: begin
        if (i_px_ready) begin
          if (w_last) begin
            w_state_nxt = StIdle;
            w_done_nxt  = 1'b1;
          end
          if (w_col_end) begin
            w_col_nxt = '0;
            w_row_nxt = r_row + DIM_W'(1);
          end else begin
            w_col_nxt = r_col + DIM_W'(1);
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_desc  <= '0;
      r_img_h <= '0;
      r_img_w <= '0;
      r_ch    <= '0;
      r_base  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_desc  <= w_desc_nxt;
      r_img_h <= w_img_h_nxt;
      r_img_w <= w_img_w_nxt;
      r_ch    <= w_ch_nxt;
      r_base  <= w_base_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Pixel outputs are zeroed outside STREAM so idle and reset look identical downstream.
  assign o_tile_ready  = (r_state == StIdle);
  assign o_px_valid    = w_streaming;
  assign o_busy        = w_streaming;
  assign o_tile_done   = r_done;
  assign o_px_addr     = w_streaming ? w_addr : '0;
  assign o_px_pad      = w_streaming & w_pad;
  assign o_px_row      = w_streaming ? r_row : '0;
  assign o_px_col      = w_streaming ? r_col : '0;
  assign o_px_tile_idx = w_streaming ? r_desc.idx : '0;
  assign o_px_last     = w_streaming & w_last;

endmodule

// File: tb/tb_tile_px_fetch.sv
// Self-checking bench for tile_px_fetch: directed windows plus randomized windows
// checked against a raster-walk reference model.
module tb_tile_px_fetch;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [15:0]        cfg_img_h = '0, cfg_img_w = '0, cfg_ch = '0;
  logic [31:0]        cfg_base = '0;
  logic               tile_valid = 1'b0;
  logic               tile_ready;
  logic signed [16:0] tile_in_row = '0, tile_in_col = '0;
  logic [15:0]        tile_in_h = '0, tile_in_w = '0, tile_idx = '0;
  logic               px_valid;
  logic               px_ready = 1'b0;
  logic [31:0]        px_addr;
  logic               px_pad, px_last, tile_done, busy;
  logic [15:0]        px_row, px_col, px_tile_idx;

  always #5 clk = ~clk;

  tile_px_fetch #(
    .DIM_W  (16),
    .ADDR_W (32),
    .CH_W   (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_cfg_img_h     (cfg_img_h),
    .i_cfg_img_w     (cfg_img_w),
    .i_cfg_channels  (cfg_ch),
    .i_cfg_base_addr (cfg_base),
    .i_tile_valid    (tile_valid),
    .o_tile_ready    (tile_ready),
    .i_tile_in_row   (tile_in_row),
    .i_tile_in_col   (tile_in_col),
    .i_tile_in_h     (tile_in_h),
    .i_tile_in_w     (tile_in_w),
    .i_tile_idx      (tile_idx),
    .o_px_valid      (px_valid),
    .i_px_ready      (px_ready),
    .o_px_addr       (px_addr),
    .o_px_pad        (px_pad),
    .o_px_row        (px_row),
    .o_px_col        (px_col),
    .o_px_tile_idx   (px_tile_idx),
    .o_px_last       (px_last),
    .o_tile_done     (tile_done),
    .o_busy          (busy)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        pad;
    logic [15:0] row;
    logic [15:0] col;
    logic        last;
    logic [15:0] idx;
  } pix_t;

  pix_t obs[$];
  pix_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   cap_timeout, cap_valid_bad, cap_ready_bad, cap_stall_bad, cap_done, cap_done_ready;
  int   cap_cycles;

  // Reference: walk the window in raster order, placing each position in the image.
  task automatic build_expected(input int img_h, img_w, ch, input logic [31:0] base,
                                input int row, col, h, w, idx);
    exp_q.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        pix_t   p;
        longint ar = longint'(row + r);
        longint ac = longint'(col + c);
        longint lin = longint'(base) + (ar * img_w + ac) * ch;
        p.pad  = (ar < 0) || (ac < 0) || (ar >= img_h) || (ac >= img_w);
        p.addr = p.pad ? 32'h0 : lin[31:0];
        p.row  = 16'(r);
        p.col  = 16'(c);
        p.last = (r == h - 1) && (c == w - 1);
        p.idx  = 16'(idx);
        exp_q.push_back(p);
      end
    end
  endtask

  // Collects accepted pixels into obs and records protocol observations; no checking here.
  task automatic capture(input int mode, input int max_cyc, input bit scramble);
    pix_t cur, prev;
    bit   stalled = 1'b0;
    bit   got_last = 1'b0;
    int   cyc = 0;
    obs.delete();
    prev = '0;
    {cap_timeout, cap_valid_bad, cap_ready_bad, cap_stall_bad, cap_done, cap_done_ready} = '0;
    while (!got_last) begin
      if (cyc >= max_cyc) begin
        cap_timeout = 1'b1;
        break;
      end
      case (mode)
        0:       px_ready = 1'b1;
        1:       px_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: px_ready = 1'($urandom_range(0, 1));
      endcase
      if (scramble) begin
        cfg_img_h   = 16'($urandom);
        cfg_img_w   = 16'($urandom);
        cfg_ch      = 16'($urandom);
        cfg_base    = $urandom;
        tile_in_row = 17'($urandom);
        tile_in_col = 17'($urandom);
        tile_in_h   = 16'($urandom);
        tile_in_w   = 16'($urandom);
        tile_idx    = 16'($urandom);
      end
      @(negedge clk);
      if (px_valid !== 1'b1) cap_valid_bad = 1'b1;
      if (tile_ready !== 1'b0 || busy !== 1'b1) cap_ready_bad = 1'b1;
      cur = '{addr: px_addr, pad: px_pad, row: px_row, col: px_col, last: px_last,
              idx: px_tile_idx};
      if (stalled && cur !== prev) cap_stall_bad = 1'b1;
      if (px_ready) begin
        obs.push_back(cur);
        if (px_last === 1'b1) got_last = 1'b1;
      end
      prev    = cur;
      stalled = !px_ready;
      cyc++;
      @(posedge clk);
      #1;
    end
    px_ready   = 1'b0;
    cap_cycles = cyc;
    if (!cap_timeout) begin
      @(negedge clk);
      cap_done       = tile_done;
      cap_done_ready = tile_ready && !busy && !px_valid;
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one descriptor in IDLE, streams it and compares everything against the model.
  task automatic test_window(input string name, input int img_h, img_w, ch,
                             input logic [31:0] base, input int row, col, h, w, idx,
                             input int mode, input bit scramble);
    build_expected(img_h, img_w, ch, base, row, col, h, w, idx);
    cfg_img_h   = 16'(img_h);
    cfg_img_w   = 16'(img_w);
    cfg_ch      = 16'(ch);
    cfg_base    = base;
    tile_in_row = 17'(row);
    tile_in_col = 17'(col);
    tile_in_h   = 16'(h);
    tile_in_w   = 16'(w);
    tile_idx    = 16'(idx);
    tile_valid  = 1'b1;
    @(negedge clk);
    n_total++;
    if (tile_ready !== 1'b1) $display("FAIL %s.accept_ready: got %b want 1", name, tile_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    tile_valid = 1'b0;
    capture(mode, h * w * 6 + 10, scramble);

    n_total++;
    if ({cap_timeout, cap_valid_bad, cap_ready_bad, cap_stall_bad} !== 4'b0)
      $display("FAIL %s.protocol: timeout/valid/ready/stall flags %b want 0000", name,
               {cap_timeout, cap_valid_bad, cap_ready_bad, cap_stall_bad});
    else n_pass++;
    n_total++;
    if (obs.size() !== exp_q.size())
      $display("FAIL %s.count: got %0d pixels want %0d", name, obs.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_total++;
      if (i >= obs.size())
        $display("FAIL %s.px%0d: missing, want %h", name, i, exp_q[i]);
      else if (obs[i] !== exp_q[i])
        $display("FAIL %s.px%0d: got addr=%h pad=%b r=%0d c=%0d last=%b idx=%0d want addr=%h pad=%b r=%0d c=%0d last=%b idx=%0d",
                 name, i, obs[i].addr, obs[i].pad, obs[i].row, obs[i].col, obs[i].last,
                 obs[i].idx, exp_q[i].addr, exp_q[i].pad, exp_q[i].row, exp_q[i].col,
                 exp_q[i].last, exp_q[i].idx);
      else n_pass++;
    end
    if (mode == 0) begin
      n_total++;
      if (cap_cycles !== h * w)
        $display("FAIL %s.cycles: got %0d want %0d", name, cap_cycles, h * w);
      else n_pass++;
    end
    n_total++;
    if ({cap_done, cap_done_ready} !== 2'b11)
      $display("FAIL %s.done: done/idle_ready got %b want 11", name, {cap_done, cap_done_ready});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (tile_done !== 1'b0) $display("FAIL %s.done_width: got %b want 0", name, tile_done);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_total++;
    if (tile_ready !== 1'b1) $display("FAIL reset.tile_ready: got %b want 1", tile_ready);
    else n_pass++;
    n_total++;
    if ({px_valid, px_pad, px_last, tile_done, busy, px_addr, px_row, px_col, px_tile_idx} !== '0)
      $display("FAIL reset.outputs: got v=%b pad=%b last=%b done=%b busy=%b addr=%h want all 0",
               px_valid, px_pad, px_last, tile_done, busy, px_addr);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_interior();
    test_window("interior", 8, 8, 3, 32'h1000, 2, 3, 2, 2, 5, 0, 1'b0);
    n_total++;
    if (obs.size() != 4)
      $display("FAIL interior.const: got %0d pixels want 4", obs.size());
    else if ({obs[0].addr, obs[1].addr, obs[2].addr, obs[3].addr} !==
             {32'h1039, 32'h103C, 32'h1051, 32'h1054} ||
             {obs[0].pad, obs[1].pad, obs[2].pad, obs[3].pad, obs[3].last} !== 5'b00001)
      $display("FAIL interior.const: got %h %h %h %h want 1039 103c 1051 1054",
               obs[0].addr, obs[1].addr, obs[2].addr, obs[3].addr);
    else n_pass++;
  endtask

  task automatic test_top_left_pad();
    logic [8:0] pads;
    test_window("top_left", 8, 8, 3, 32'h1000, -1, -1, 3, 3, 9, 0, 1'b0);
    n_total++;
    if (obs.size() != 9) begin
      $display("FAIL top_left.const: got %0d pixels want 9", obs.size());
    end else begin
      for (int i = 0; i < 9; i++) pads[8-i] = obs[i].pad;
      if (pads !== 9'b111100100 || obs[4].addr !== 32'h1000 || obs[8].addr !== 32'h101B)
        $display("FAIL top_left.const: got pads=%b a4=%h a8=%h want 111100100 1000 101b",
                 pads, obs[4].addr, obs[8].addr);
      else n_pass++;
    end
  endtask

  task automatic test_bottom_right();
    test_window("bottom_right", 8, 8, 3, 32'h1000, 7, 7, 2, 2, 3, 0, 1'b0);
    n_total++;
    if (obs.size() != 4)
      $display("FAIL bottom_right.const: got %0d pixels want 4", obs.size());
    else if ({obs[0].pad, obs[1].pad, obs[2].pad, obs[3].pad} !== 4'b0111 ||
             {obs[0].addr, obs[1].addr, obs[2].addr, obs[3].addr} !== {32'h10BD, 96'h0})
      $display("FAIL bottom_right.const: got pads=%b a0=%h want 0111 10bd",
               {obs[0].pad, obs[1].pad, obs[2].pad, obs[3].pad}, obs[0].addr);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    test_window("backpressure", 8, 8, 3, 32'h1000, 2, 3, 2, 2, 5, 1, 1'b0);
    n_total++;
    if (obs.size() != 4)
      $display("FAIL backpressure.const: got %0d pixels want 4", obs.size());
    else if ({obs[0].addr, obs[1].addr, obs[2].addr, obs[3].addr} !==
             {32'h1039, 32'h103C, 32'h1051, 32'h1054})
      $display("FAIL backpressure.const: got %h %h %h %h want 1039 103c 1051 1054",
               obs[0].addr, obs[1].addr, obs[2].addr, obs[3].addr);
    else n_pass++;
  endtask

  task automatic test_degenerate();
    for (int k = 0; k < 2; k++) begin
      tile_in_row = 17'sd0;
      tile_in_col = 17'sd0;
      tile_in_h   = (k == 0) ? 16'd0 : 16'd3;
      tile_in_w   = (k == 0) ? 16'd3 : 16'd0;
      tile_valid  = 1'b1;
      @(posedge clk);
      #1;
      tile_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if ({px_valid, busy, tile_ready, tile_done} !== 4'b0011)
        $display("FAIL degenerate%0d.pulse: valid/busy/ready/done got %b want 0011", k,
                 {px_valid, busy, tile_ready, tile_done});
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({px_valid, tile_done} !== 2'b00)
        $display("FAIL degenerate%0d.after: valid/done got %b want 00", k, {px_valid, tile_done});
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    pix_t first_a[$];
    cfg_img_h   = 16'd8;
    cfg_img_w   = 16'd8;
    cfg_ch      = 16'd3;
    cfg_base    = 32'h1000;
    tile_in_row = 17'sd2;
    tile_in_col = 17'sd3;
    tile_in_h   = 16'd2;
    tile_in_w   = 16'd2;
    tile_idx    = 16'd11;
    tile_valid  = 1'b1;
    @(posedge clk);
    #1;
    // Second descriptor held valid for the whole first tile; single-pixel window.
    tile_in_row = 17'sd4;
    tile_in_col = 17'sd5;
    tile_in_h   = 16'd1;
    tile_in_w   = 16'd1;
    tile_idx    = 16'd12;
    capture(0, 20, 1'b0);
    tile_valid = 1'b0;
    first_a = obs;
    build_expected(8, 8, 3, 32'h1000, 2, 3, 2, 2, 11);
    n_total++;
    if (first_a.size() != 4 || first_a[3] !== exp_q[3] || !cap_done || !cap_done_ready)
      $display("FAIL b2b.first: got %0d pixels done=%b idle_ready=%b want 4 1 1",
               first_a.size(), cap_done, cap_done_ready);
    else n_pass++;
    capture(0, 5, 1'b0);
    build_expected(8, 8, 3, 32'h1000, 4, 5, 1, 1, 12);
    n_total++;
    if ({cap_timeout, cap_valid_bad, cap_ready_bad} !== 3'b000 || cap_cycles !== 1)
      $display("FAIL b2b.no_bubble: flags=%b cycles=%0d want 000 1",
               {cap_timeout, cap_valid_bad, cap_ready_bad}, cap_cycles);
    else n_pass++;
    n_total++;
    if (obs.size() != 1 || obs[0] !== exp_q[0])
      $display("FAIL b2b.second: got %0d pixels addr=%h last=%b want 1 %h 1", obs.size(),
               (obs.size() > 0) ? obs[0].addr : 32'h0, (obs.size() > 0) ? obs[0].last : 1'b0,
               exp_q[0].addr);
    else n_pass++;
    n_total++;
    if (cap_done !== 1'b1) $display("FAIL b2b.second_done: got %b want 1", cap_done);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    cfg_img_h   = 16'd8;
    cfg_img_w   = 16'd8;
    cfg_ch      = 16'd3;
    cfg_base    = 32'h1000;
    tile_in_row = 17'sd1;
    tile_in_col = 17'sd1;
    tile_in_h   = 16'd3;
    tile_in_w   = 16'd3;
    tile_idx    = 16'd7;
    tile_valid  = 1'b1;
    @(posedge clk);
    #1;
    tile_valid = 1'b0;
    px_ready   = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({px_valid, px_pad, px_last, tile_done, busy, px_addr, px_row, px_col, px_tile_idx} !== '0
        || tile_ready !== 1'b1)
      $display("FAIL reset_mid.outputs: got v=%b busy=%b col=%0d addr=%h ready=%b want 0 0 0 0 1",
               px_valid, busy, px_col, px_addr, tile_ready);
    else n_pass++;
    px_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++;
      if ({tile_done, px_valid} !== 2'b00)
        $display("FAIL reset_mid.no_done%0d: done/valid got %b want 00", i, {tile_done, px_valid});
      else n_pass++;
    end
    @(posedge clk);
    #1;
    test_window("after_reset", 8, 8, 3, 32'h1000, 1, 1, 2, 2, 8, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      int ih = $urandom_range(1, 10);
      int iw = $urandom_range(1, 10);
      int r0 = int'($urandom_range(0, ih + 4)) - 3;
      int c0 = int'($urandom_range(0, iw + 4)) - 3;
      test_window($sformatf("random%0d", t), ih, iw, $urandom_range(1, 4), $urandom,
                  r0, c0, $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 65535),
                  2, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_interior();
    test_top_left_pad();
    test_bottom_right();
    test_backpressure();
    test_degenerate();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tile_px_fetch.md
Name: tile_px_fetch

Overview:
- Consumer end of the tile-descriptor valid/ready interface driven by the tiling controller.
- Accepts one input-window descriptor at a time: signed origin, height, width and tile index.
- Walks the window in raster order and emits one pixel request per position: HWC byte/element address of channel 0, or a zero-pad marker when the position falls outside the image.
- Feeds the line-buffer / DMA read path ahead of the conv datapath.

Parameters:
DIM_W, 16, width of image/tile dimension fields (origins are DIM_W+1 signed)
ADDR_W, 32, width of generated addresses
CH_W, 16, width of channel-count field

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_img_h  in  DIM_W  image height; quasi-static, sampled on tile accept
cfg_img_w  in  DIM_W  image width; sampled on tile accept
cfg_channels  in  CH_W  channels per pixel (address stride per pixel); sampled on tile accept
cfg_base_addr  in  ADDR_W  address of pixel (0,0) ch0; sampled on tile accept
tile_valid  in  1  descriptor valid
tile_ready  out  1  descriptor accept
tile_in_row  in  DIM_W+1  signed window top row (may be negative)
tile_in_col  in  DIM_W+1  signed window left col (may be negative)
tile_in_h  in  DIM_W  window height
tile_in_w  in  DIM_W  window width
tile_idx  in  DIM_W  tile index, passed through
px_valid  out  1  pixel request valid
px_ready  in  1  pixel request accept
px_addr  out  ADDR_W  base + (r*img_w + c)*channels; 0 when px_pad
px_pad  out  1  position outside image, consumer inserts zeros
px_row  out  DIM_W  row offset within window
px_col  out  DIM_W  col offset within window
px_tile_idx  out  DIM_W  latched tile_idx
px_last  out  1  final pixel of the window
tile_done  out  1  one-cycle pulse after last pixel accepted or degenerate tile dropped
busy  out  1  high in STREAM

Behaviour:
- Reset values (rst_n low, async): state IDLE; all counters, latched fields, px_*, tile_done and busy = 0; tile_ready = 1 once state is IDLE.
- FSM states: IDLE, STREAM.
- In IDLE: tile_ready=1, px_valid=0.
  - On tile_valid&&tile_ready: latch descriptor and cfg_*; clear row/col counters.
  - If tile_in_h==0 or tile_in_w==0: stay IDLE and set tile_done=1 for the next cycle; no pixels are emitted.
  - Otherwise go to STREAM.
- In STREAM: tile_ready=0, px_valid=1, busy=1.
  - First px_valid is the cycle after the accept edge.
- Pixel outputs are combinational from the counters and latched fields.
  - All px_* hold stable while px_valid && !px_ready.
- Stepping on each px handshake:
  - If col == w-1: col←0 and row←row+1; otherwise col←col+1.
- px_last = (row==h-1)&&(col==w-1).
  - On the px_last handshake: go to IDLE and set tile_done=1 for exactly one cycle.
  - tile_ready is high in that same following cycle, so back-to-back tiles lose one bubble cycle only.
- Absolute position:
  - r = in_row + row, c = in_col + col, computed signed at DIM_W+2 bits.
  - px_pad = r<0 || c<0 || r>=img_h || c>=img_w.
- Address arithmetic:
  - Computed at ≥ 2*DIM_W+CH_W bits unsigned from non-negative r,c.
  - Truncated to ADDR_W after adding base; wrap-around is silent.
  - Forced to 0 when px_pad.
- Single-pixel window (h=w=1): px_last is high on the first and only request.
- tile_done and tile_valid in the same cycle: the new tile is accepted normally.
- Descriptor inputs are ignored outside IDLE.
- cfg_* changes during STREAM have no effect on the current tile.
- Reset mid-STREAM: immediate return to IDLE with all outputs 0; no tile_done pulse is issued.

Decomposition:
- Shared package cnn_tile_pkg holds:
  - tile descriptor struct (in_row, in_col, in_h, in_w, idx);
  - FSM state enum;
  - DIM_W default constant, also used by the tiling controller.
- One sub-module, tile_px_addr: combinational r/c bounds check plus address multiply-add. It keeps the wide arithmetic isolated for retiming later.

Test Plan:
- Interior window, img 8x8, ch=3, base=0x1000, in_row=2, in_col=3, h=2, w=2, px_ready=1 → addrs 0x1039, 0x103C, 0x1051, 0x1054; pad=0; px_last on the 4th; tile_done one cycle later.
- Top-left pad, same cfg, in_row=-1, in_col=-1, h=3, w=3 → 9 requests with pad pattern 1,1,1,1,0,0,1,0,0; pixel (row1,col1) addr 0x1000; (row2,col2) addr 0x101B.
- Bottom-right overrun, in_row=7, in_col=7, h=2, w=2 → pad 0,1,1,1; first addr 0x10BD; other addrs 0.
- Backpressure: toggle px_ready 1,0,0,1,… on the interior tile → identical 4-address sequence, outputs stable while stalled, tile_ready stays 0 until done.
- Degenerate h=0 and back-to-back tiles:
  - h=0 → no px_valid, tile_done pulse next cycle.
  - Two valid tiles presented continuously → second accepted the cycle after the first's last handshake.
- Reset asserted during the 2nd pixel of a 3x3 tile → all outputs 0 asynchronously, no tile_done; next descriptor is accepted and streams from (0,0).
